reg_write_arbiter: RTL

Shares one WIDTH-bit storage register between NUM_REQ requesters in the processor datapath.
- Round-robin arbitration with a per-requester valid/grant handshake.
- Commits the winning requester's data into the register and reports which requester owns the current value.
- Sits between the stage-level write sources (e.g. ALU/load/CSR paths) and the consumer of the shared register.

---
 rtl/reg_write_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register between NUM_REQ write sources.
// Optional ARB_LOCK_EN: a requester asserting req_lock keeps the grant for back-to-back writes.
module reg_write_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]       req_lock,
    output logic [NUM_REQ-1:0]       grant,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [IDW-1:0]           q_owner,
    output logic                     busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     ptr, ptr_nxt;
    logic [IDW-1:0]     sel, sel_nxt, sel_inc;
    logic [IDW-1:0]     pick;
    logic               found;
    int unsigned        idx;
    logic [WIDTH-1:0]   sel_data;
    logic [WIDTH-1:0]   q_nxt;
    logic [IDW-1:0]     owner_nxt;
    logic               q_valid_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic               lock_sel;

`ifdef ARB_LOCK_EN
    assign lock_sel = req_lock[sel];
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign lock_sel    = 1'b0;
`endif

    // First valid requester at or after ptr, wrapping at NUM_REQ-1.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    assign sel_inc  = (sel == IDW'(NUM_REQ - 1)) ? '0 : sel + IDW'(1);
    assign sel_data = req_data[32'(sel)*WIDTH +: WIDTH];

    // Next-state and registered-output decode.
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        sel_nxt     = sel;
        q_nxt       = q;
        owner_nxt   = q_owner;
        q_valid_nxt = 1'b0;
        grant_nxt   = '0;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_nxt   = pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                state_nxt = IDLE;
                if (req_valid[sel]) begin
                    q_nxt       = sel_data;
                    owner_nxt   = sel;
                    q_valid_nxt = 1'b1;
                    if (lock_sel) begin
                        state_nxt = GRANT;
                    end else begin
                        ptr_nxt = sel_inc;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == GRANT) begin
            grant_nxt[sel_nxt] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= '0;
            sel     <= '0;
            grant   <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            q_owner <= '0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            sel     <= sel_nxt;
            grant   <= grant_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            q_owner <= owner_nxt;
            busy    <= (state_nxt != IDLE);
        end
    end

endmodule
